ahb_sram_slave: RTL and testbench

- Synthesizable AHB-Lite slave that fronts a single-port synchronous SRAM macro using active-low cen/wen/ben.
- Replaces the behavioural fixed-latency memory model with a parametrised block: configurable depth, base address and wait states.
- Adds byte/halfword/word lane masking, alignment and range checking with a two-cycle ERROR response, and pipelined back-to-back transfers.
- Sits between the core's AHB master port and the SRAM macro in the top level.

---
 rtl/ahb_sram_slave_if.sv | 27 ++
 rtl/ahb_sram_slave.sv | 166 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and ahb_sram_slave.
// Signals:
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY  master -> slave
//   HREADYOUT, HRESP, HRDATA                            slave  -> master
// HREADY is the bus-level ready (HREADYIN) driven by the interconnect.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a single-port synchronous SRAM macro (active-low cen/wen/ben).
// Adds LATENCY wait states per data phase, byte/half/word lane masking, alignment/range
// checking with a two-cycle ERROR response, and back-to-back pipelined transfers.
// Ports:
//   HCLK, HRESETn       clock, synchronous active-low reset
//   ahb (slave modport) AHB-Lite bus signals
//   sram_cen/wen/ben    SRAM chip enable, write enable, byte enables (all active low)
//   sram_addr           SRAM word address
//   sram_din/sram_dout  SRAM write / read data (dout valid one cycle after a read issue)
module ahb_sram_slave #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_sram_slave_if.slave       ahb,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [3:0]            sram_ben,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [31:0]           sram_din,
  input  logic [31:0]           sram_dout
);

  localparam logic [3:0] LatCnt = LATENCY[3:0];

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StWr,
    StRdIssue,
    StRdData,
    StErr1,
    StErr2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;

  logic       accept;
  logic       bad_size;
  logic       misaligned;
  logic       out_of_range;
  logic       illegal;
  logic       can_start;
  logic [3:0] lane;

  assign accept       = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign bad_size     = ahb.HSIZE > 3'd2;
  assign misaligned   = ((ahb.HSIZE == 3'd1) & ahb.HADDR[0]) |
                        ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] != 2'b00));
  assign out_of_range = ahb.HADDR[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];
  assign illegal      = bad_size | misaligned | out_of_range;

  // HTRANS[0] only separates IDLE from BUSY and NONSEQ from SEQ; both pairs behave alike here.
  logic unused_ok;
  assign unused_ok = ahb.HTRANS[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    can_start = 1'b0;

    unique case (state_q)
      StIdle: can_start = 1'b1;
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = write_q ? StWr : StRdIssue;
        end
      end
      StWr, StRdData, StErr2: begin
        // Completing cycle: a new accept chains directly into the next transfer.
        can_start = 1'b1;
        state_d   = StIdle;
      end
      StRdIssue: state_d = StRdData;
      StErr1:    state_d = StErr2;
      default:   state_d = StIdle;
    endcase

    if (can_start && accept) begin
      addr_d  = ahb.HADDR[ADDR_W+1:0];
      write_d = ahb.HWRITE;
      size_d  = ahb.HSIZE[1:0];
      if (illegal) begin
        state_d = StErr1;
      end else if (LATENCY == 0) begin
        state_d = ahb.HWRITE ? StWr : StRdIssue;
      end else begin
        state_d = StWait;
        cnt_d   = LatCnt;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    unique case (size_q)
      2'd0:    lane = 4'b0001 << addr_q[1:0];
      2'd1:    lane = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane = 4'b1111;
    endcase
  end

  // Outputs are held at idle values while HRESETn is low so a write in flight cannot
  // reach the macro during the reset cycle.
  always_comb begin
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = 1'b0;
    ahb.HRDATA    = 32'h0;
    sram_cen      = 1'b1;
    sram_wen      = 1'b1;
    sram_ben      = 4'hF;
    sram_addr     = '0;
    sram_din      = 32'h0;
    if (HRESETn) begin
      if (state_q != StIdle) sram_addr = addr_q[ADDR_W+1:2];
      unique case (state_q)
        StWait: ahb.HREADYOUT = 1'b0;
        StWr: begin
          sram_cen = 1'b0;
          sram_wen = 1'b0;
          sram_ben = ~lane;
          sram_din = ahb.HWDATA;
        end
        StRdIssue: begin
          sram_cen      = 1'b0;
          ahb.HREADYOUT = 1'b0;
        end
        StRdData: ahb.HRDATA = sram_dout;
        StErr1: begin
          ahb.HRESP     = 1'b1;
          ahb.HREADYOUT = 1'b0;
        end
        StErr2:  ahb.HRESP = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with LATENCY=2 and one with LATENCY=0, each with
// a behavioural SRAM. A pipelined AHB driver pushes expectations at address-phase time and
// pops them when the data phase completes.
module tb_ahb_sram_slave;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic rst2_n, rst0_n;
  int   sel;  // 0: LATENCY=2 instance, 1: LATENCY=0 instance

  logic        h_sel;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [2:0]  h_size;
  logic [31:0] h_wdata;

  ahb_sram_slave_if bus2();
  ahb_sram_slave_if bus0();

  assign bus2.HSEL   = h_sel & (sel == 0);
  assign bus2.HADDR  = h_addr;
  assign bus2.HTRANS = (sel == 0) ? h_trans : 2'b00;
  assign bus2.HWRITE = h_write;
  assign bus2.HSIZE  = h_size;
  assign bus2.HWDATA = h_wdata;
  assign bus2.HREADY = bus2.HREADYOUT;
  assign bus0.HSEL   = h_sel & (sel == 1);
  assign bus0.HADDR  = h_addr;
  assign bus0.HTRANS = (sel == 1) ? h_trans : 2'b00;
  assign bus0.HWRITE = h_write;
  assign bus0.HSIZE  = h_size;
  assign bus0.HWDATA = h_wdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  logic       cen2, wen2, cen0, wen0;
  logic [3:0] ben2, ben0;
  logic [9:0] addr2, addr0;
  logic [31:0] din2, din0, dout2, dout0;
  logic [31:0] mem2 [1024];
  logic [31:0] mem0 [1024];

  ahb_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(rst2_n), .ahb(bus2.slave),
    .sram_cen(cen2), .sram_wen(wen2), .sram_ben(ben2), .sram_addr(addr2),
    .sram_din(din2), .sram_dout(dout2)
  );

  ahb_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(rst0_n), .ahb(bus0.slave),
    .sram_cen(cen0), .sram_wen(wen0), .sram_ben(ben0), .sram_addr(addr0),
    .sram_din(din0), .sram_dout(dout0)
  );

  always @(posedge HCLK) begin
    if (!cen2) begin
      if (!wen2) begin
        for (int b = 0; b < 4; b++) if (!ben2[b]) mem2[addr2][b*8 +: 8] <= din2[b*8 +: 8];
      end else begin
        dout2 <= mem2[addr2];
      end
    end
  end

  always @(posedge HCLK) begin
    if (!cen0) begin
      if (!wen0) begin
        for (int b = 0; b < 4; b++) if (!ben0[b]) mem0[addr0][b*8 +: 8] <= din0[b*8 +: 8];
      end else begin
        dout0 <= mem0[addr0];
      end
    end
  end

  logic        o_ready, o_resp, o_cen, o_wen;
  logic [31:0] o_rdata, o_din;
  logic [3:0]  o_ben;
  logic [9:0]  o_addr;
  assign o_ready = sel ? bus0.HREADYOUT : bus2.HREADYOUT;
  assign o_resp  = sel ? bus0.HRESP     : bus2.HRESP;
  assign o_rdata = sel ? bus0.HRDATA    : bus2.HRDATA;
  assign o_cen   = sel ? cen0  : cen2;
  assign o_wen   = sel ? wen0  : wen2;
  assign o_ben   = sel ? ben0  : ben2;
  assign o_addr  = sel ? addr0 : addr2;
  assign o_din   = sel ? din0  : din2;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    logic        wr;
    logic        err;
    int          len;
    logic [31:0] rdata;
    logic [3:0]  ben;
    logic [9:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] model [2][1024];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic add(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                     input logic [31:0] wd);
    stim_t s;
    s.addr = a; s.size = sz; s.wr = wr; s.wdata = wd;
    stim_q.push_back(s);
  endtask

  // Builds the expected outcome from the address-phase stimulus and updates the model.
  function automatic exp_t make_exp(stim_t s);
    exp_t       e;
    logic [3:0] m;
    logic [9:0] wi;
    int         lat;
    lat   = (sel == 1) ? 0 : 2;
    e.err = (s.size > 3'd2) || (s.size == 3'd1 && s.addr[0]) ||
            (s.size == 3'd2 && s.addr[1:0] != 2'b00) || (s.addr[31:12] != 20'h0);
    if (s.size == 3'd0)      m = 4'b0001 << s.addr[1:0];
    else if (s.size == 3'd1) m = s.addr[1] ? 4'b1100 : 4'b0011;
    else                     m = 4'b1111;
    wi      = s.addr[11:2];
    e.wr    = s.wr;
    e.ben   = ~m;
    e.waddr = wi;
    e.wdata = s.wdata;
    e.len   = e.err ? 2 : (s.wr ? lat + 1 : lat + 2);
    e.rdata = model[sel][wi];
    if (!e.err && s.wr)
      for (int b = 0; b < 4; b++) if (m[b]) model[sel][wi][b*8 +: 8] = s.wdata[b*8 +: 8];
    return e;
  endfunction

  task automatic bus_idle();
    h_sel = 1'b0; h_trans = 2'b00; h_write = 1'b0; h_size = 3'd0; h_addr = 32'h0;
  endtask

  task automatic drive_addr(input stim_t s);
    h_sel = 1'b1; h_trans = 2'b10; h_addr = s.addr; h_size = s.size; h_write = s.wr;
  endtask

  // Pipelined driver: address phase of item n+1 overlaps the data phase of item n.
  task automatic run_stim(input string name);
    stim_t       s, cur;
    exp_t        e;
    logic        rdy, r_or, r_and, cen_low, have_addr, dp;
    int          len, guard;
    @(posedge HCLK); #1;
    dp = 1'b0; have_addr = 1'b0; guard = 0; len = 0;
    r_or = 1'b0; r_and = 1'b1; cen_low = 1'b0;
    if (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive_addr(s); exp_q.push_back(make_exp(s)); have_addr = 1'b1;
    end
    while ((have_addr || dp) && guard < 500) begin
      guard++;
      @(negedge HCLK);
      rdy = o_ready;
      if (dp) begin
        len++;
        r_or  = r_or | o_resp;
        r_and = r_and & o_resp;
        if (!o_cen) cen_low = 1'b1;
        if (rdy) begin
          e = exp_q.pop_front();
          tests_run++;
          if (len !== e.len) begin
            tests_failed++;
            $display("FAIL %s len @%h: got %0d want %0d", name, cur.addr, len, e.len);
          end
          tests_run++;
          if ({r_or, r_and} !== (e.err ? 2'b11 : 2'b00)) begin
            tests_failed++;
            $display("FAIL %s resp @%h: got or/and=%b%b want err=%b", name, cur.addr,
                     r_or, r_and, e.err);
          end
          if (e.err) begin
            tests_run++;
            if (cen_low !== 1'b0) begin
              tests_failed++;
              $display("FAIL %s err_cen @%h: got cen low seen=%b want 0", name, cur.addr,
                       cen_low);
            end
          end else if (e.wr) begin
            tests_run++;
            if ({o_cen, o_wen, o_ben, o_addr, o_din} !==
                {1'b0, 1'b0, e.ben, e.waddr, e.wdata}) begin
              tests_failed++;
              $display("FAIL %s wr_pins @%h: got cen=%b wen=%b ben=%b a=%h d=%h want ben=%b a=%h d=%h",
                       name, cur.addr, o_cen, o_wen, o_ben, o_addr, o_din, e.ben, e.waddr,
                       e.wdata);
            end
          end else begin
            tests_run++;
            if (o_rdata !== e.rdata) begin
              tests_failed++;
              $display("FAIL %s rdata @%h: got %h want %h", name, cur.addr, o_rdata, e.rdata);
            end
          end
          dp = 1'b0;
        end
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        if (have_addr) begin
          dp = 1'b1; cur = s; len = 0; r_or = 1'b0; r_and = 1'b1; cen_low = 1'b0;
          h_wdata = s.wr ? s.wdata : 32'h0;
        end
        if (stim_q.size() > 0) begin
          s = stim_q.pop_front(); drive_addr(s); exp_q.push_back(make_exp(s));
          have_addr = 1'b1;
        end else begin
          bus_idle(); have_addr = 1'b0;
        end
      end
    end
    if (have_addr || dp) begin
      tests_run++; tests_failed++;
      $display("FAIL %s timeout: got busy after %0d cycles want done", name, guard);
      bus_idle();
    end
  endtask

  task automatic test_reset();
    rst2_n = 1'b0; rst0_n = 1'b0; bus_idle(); h_wdata = 32'h0;
    repeat (2) @(posedge HCLK);
    for (int i = 0; i < 2; i++) begin
      sel = i;
      @(negedge HCLK);
      tests_run++;
      if ({o_ready, o_resp, o_rdata, o_cen, o_wen, o_ben, o_addr, o_din} !==
          {1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 10'h0, 32'h0}) begin
        tests_failed++;
        $display("FAIL reset_outputs dut%0d: got rdy=%b resp=%b rd=%h cen=%b wen=%b ben=%b a=%h d=%h want idle",
                 i, o_ready, o_resp, o_rdata, o_cen, o_wen, o_ben, o_addr, o_din);
      end
    end
    @(posedge HCLK); #1;
    rst2_n = 1'b1; rst0_n = 1'b1; sel = 0;
  endtask

  task automatic test_word_rw();
    sel = 0;
    add(32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
    add(32'h10, 3'd2, 1'b0, 32'h0);
    add(32'h14, 3'd2, 1'b1, 32'h1234_5678);
    run_stim("word_rw");
  endtask

  task automatic test_lanes();
    sel = 0;
    add(32'h13, 3'd0, 1'b1, 32'hAA00_0000);
    add(32'h16, 3'd1, 1'b1, 32'h5555_0000);
    add(32'h10, 3'd2, 1'b0, 32'h0);
    add(32'h14, 3'd2, 1'b0, 32'h0);
    add(32'h11, 3'd0, 1'b0, 32'h0);
    run_stim("lanes");
  endtask

  task automatic test_errors();
    sel = 0;
    add(32'h12, 3'd2, 1'b1, 32'hFFFF_FFFF);
    add(32'h00, 3'd3, 1'b0, 32'h0);
    add(32'h11, 3'd1, 1'b1, 32'h0);
    add(32'h10, 3'd2, 1'b0, 32'h0);
    run_stim("errors");
  endtask

  task automatic test_range();
    sel = 0;
    add(32'h1000, 3'd2, 1'b1, 32'h0BAD_0BAD);
    add(32'hFFC,  3'd2, 1'b1, 32'hCAFE_F00D);
    add(32'hFFC,  3'd2, 1'b0, 32'h0);
    add(32'h1000, 3'd2, 1'b0, 32'h0);
    run_stim("range");
  endtask

  task automatic test_back_to_back();
    sel = 1;
    add(32'h0, 3'd2, 1'b1, 32'h0101_0101);
    add(32'h4, 3'd2, 1'b1, 32'h0202_0202);
    add(32'h8, 3'd2, 1'b1, 32'h0303_0303);
    add(32'h0, 3'd2, 1'b0, 32'h0);
    add(32'h4, 3'd2, 1'b0, 32'h0);
    add(32'h8, 3'd2, 1'b0, 32'h0);
    add(32'h9, 3'd0, 1'b1, 32'h0000_7700);
    add(32'h8, 3'd2, 1'b0, 32'h0);
    run_stim("back_to_back");
  endtask

  // Reset asserted one cycle after the accept of a write: in WAIT for LATENCY=2,
  // in WR for LATENCY=0. The old word must survive.
  task automatic test_reset_mid(input int which);
    logic cen_low;
    sel = which;
    add(32'h20, 3'd2, 1'b1, 32'h1111_1111);
    run_stim("reset_mid_pre");
    h_sel = 1'b1; h_trans = 2'b10; h_addr = 32'h20; h_write = 1'b1; h_size = 3'd2;
    @(posedge HCLK); #1;
    bus_idle();
    h_wdata = 32'h2222_2222;
    if (which == 0) rst2_n = 1'b0; else rst0_n = 1'b0;
    @(negedge HCLK);
    tests_run++;
    if (o_cen !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_cen dut%0d: got cen=%b want 1", which, o_cen);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    tests_run++;
    if ({o_cen, o_ready, o_resp} !== 3'b110) begin
      tests_failed++;
      $display("FAIL reset_mid_after dut%0d: got cen/rdy/resp=%b%b%b want 110", which, o_cen,
               o_ready, o_resp);
    end
    @(posedge HCLK); #1;
    rst2_n = 1'b1; rst0_n = 1'b1;
    cen_low = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      if (!o_cen) cen_low = 1'b1;
    end
    tests_run++;
    if (cen_low !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_idle dut%0d: got cen low seen=%b want 0", which, cen_low);
    end
    add(32'h20, 3'd2, 1'b0, 32'h0);
    run_stim("reset_mid_read");
  endtask

  initial begin
    sel = 0;
    h_wdata = 32'h0;
    bus_idle();
    test_reset();
    test_word_rw();
    test_lanes();
    test_errors();
    test_range();
    test_back_to_back();
    test_reset_mid(0);
    test_reset_mid(1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog");
  end

endmodule
